// File: rtl/wb_arbiter_2m_pkg.sv
// rtl/wb_arbiter_2m_pkg.sv - shared state encoding and default widths for wb_arbiter_2m
//
// Contents:
//   arb_state_t  : arbiter state encoding (IDLE=0, GNT0=1, GNT1=2, ABORT=3)
//   DEF_ADDR_W   : default Wishbone address width
//   DEF_DATA_W   : default Wishbone data width
//   DEF_TIMEOUT  : default stall-cycle limit before abort
//   CNT_W        : width of the stall counter
package wb_arbiter_2m_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    localparam int DEF_ADDR_W  = 16;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TIMEOUT = 64;
    localparam int CNT_W       = 16;

endpackage

// File: rtl/wb_arbiter_2m.sv
// rtl/wb_arbiter_2m.sv - two-master round-robin Wishbone write arbiter
//
// Shares one write-only Wishbone slave between master 0 and master 1.
// Optional feature macro: ARB_TIMEOUT_EN (stall timeout with err pulse and ABORT state).
//
// Ports:
//   clk                 : clock, rising edge
//   rst                 : asynchronous active-low reset
//   m0_adr/m0_dat       : master 0 address / write data
//   m0_we/m0_cyc/m0_stb : master 0 write enable, cycle, strobe
//   m0_ack/m0_err       : master 0 acknowledge / error
//   m1_*                : same set for master 1
//   s_adr/s_dat         : slave address / write data
//   s_we/s_cyc/s_stb    : slave write enable, cycle, strobe
//   s_ack               : slave acknowledge
module wb_arbiter_2m
    import wb_arbiter_2m_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] m0_adr,
    input  logic [DATA_W-1:0] m0_dat,
    input  logic              m0_we,
    input  logic              m0_cyc,
    input  logic              m0_stb,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic [ADDR_W-1:0] m1_adr,
    input  logic [DATA_W-1:0] m1_dat,
    input  logic              m1_we,
    input  logic              m1_cyc,
    input  logic              m1_stb,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] s_adr,
    output logic [DATA_W-1:0] s_dat,
    output logic              s_we,
    output logic              s_cyc,
    output logic              s_stb,
    input  logic              s_ack
);

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t state;
    arb_state_t next_state;
    logic       ptr;          // last granted master; 1 after reset so m0 wins the first tie
    logic       timeout_hit;  // stall limit reached this cycle with no ack
    logic       err0_q;
    logic       err1_q;

    // State register and round-robin pointer. The pointer follows every entry
    // into a grant state, including a direct GNT0 <-> GNT1 hand-over.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            ptr   <= 1'b1;
        end else begin
            state <= next_state;
            if (next_state == ST_GNT0 && state != ST_GNT0) begin
                ptr <= 1'b0;
            end else if (next_state == ST_GNT1 && state != ST_GNT1) begin
                ptr <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (m0_cyc && m1_cyc) begin
                    next_state = ptr ? ST_GNT0 : ST_GNT1;
                end else if (m0_cyc) begin
                    next_state = ST_GNT0;
                end else if (m1_cyc) begin
                    next_state = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (timeout_hit) begin
                    next_state = ST_ABORT;
                end else if (!m0_cyc) begin
                    next_state = m1_cyc ? ST_GNT1 : ST_IDLE;
                end
            end
            ST_GNT1: begin
                if (timeout_hit) begin
                    next_state = ST_ABORT;
                end else if (!m1_cyc) begin
                    next_state = m0_cyc ? ST_GNT0 : ST_IDLE;
                end
            end
            ST_ABORT: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Slave bus mux. Acks are gated by the granted strobe so a stray s_ack
    // with no strobe never reaches a master.
    always_comb begin
        s_adr  = '0;
        s_dat  = '0;
        s_we   = 1'b0;
        s_cyc  = 1'b0;
        s_stb  = 1'b0;
        m0_ack = 1'b0;
        m1_ack = 1'b0;
        case (state)
            ST_GNT0: begin
                s_adr  = m0_adr;
                s_dat  = m0_dat;
                s_we   = m0_we;
                s_cyc  = m0_cyc;
                s_stb  = m0_stb;
                m0_ack = s_ack & m0_stb;
            end
            ST_GNT1: begin
                s_adr  = m1_adr;
                s_dat  = m1_dat;
                s_we   = m1_we;
                s_cyc  = m1_cyc;
                s_stb  = m1_stb;
                m1_ack = s_ack & m1_stb;
            end
            default: ;
        endcase
    end

    assign m0_err = err0_q;
    assign m1_err = err1_q;

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] stall_cnt;
    logic             granted;

    assign granted     = (state == ST_GNT0) || (state == ST_GNT1);
    assign timeout_hit = granted && s_stb && !s_ack && (stall_cnt == TIMEOUT_LAST);

    // err is registered so it lines up with the single ABORT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            err0_q <= timeout_hit && (state == ST_GNT0);
            err1_q <= timeout_hit && (state == ST_GNT1);
            if ((next_state != state) || (s_ack && s_stb)) begin
                stall_cnt <= '0;
            end else if (granted && s_stb) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end
`else
    logic unused_timeout;

    // keeps TIMEOUT referenced in builds without the abort feature
    assign unused_timeout = ^TIMEOUT_LAST;
    assign timeout_hit    = 1'b0;
    assign err0_q         = 1'b0;
    assign err1_q         = 1'b0;
`endif

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// tb/tb_wb_arbiter_2m.sv - directed self-checking bench for wb_arbiter_2m
module tb_wb_arbiter_2m;

    logic        clk;
    logic        rst;
    logic [15:0] m0_adr;
    logic [31:0] m0_dat;
    logic        m0_we;
    logic        m0_cyc;
    logic        m0_stb;
    logic        m0_ack;
    logic        m0_err;
    logic [15:0] m1_adr;
    logic [31:0] m1_dat;
    logic        m1_we;
    logic        m1_cyc;
    logic        m1_stb;
    logic        m1_ack;
    logic        m1_err;
    logic [15:0] s_adr;
    logic [31:0] s_dat;
    logic        s_we;
    logic        s_cyc;
    logic        s_stb;
    logic        s_ack;

    int n_cmp;
    int n_bad;

    // {s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err}
    wire [6:0] ctl = {s_cyc, s_stb, s_we, m0_ack, m1_ack, m0_err, m1_err};

    wb_arbiter_2m #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .TIMEOUT (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m0_adr (m0_adr),
        .m0_dat (m0_dat),
        .m0_we  (m0_we),
        .m0_cyc (m0_cyc),
        .m0_stb (m0_stb),
        .m0_ack (m0_ack),
        .m0_err (m0_err),
        .m1_adr (m1_adr),
        .m1_dat (m1_dat),
        .m1_we  (m1_we),
        .m1_cyc (m1_cyc),
        .m1_stb (m1_stb),
        .m1_ack (m1_ack),
        .m1_err (m1_err),
        .s_adr  (s_adr),
        .s_dat  (s_dat),
        .s_we   (s_we),
        .s_cyc  (s_cyc),
        .s_stb  (s_stb),
        .s_ack  (s_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs;
        m0_adr = '0; m0_dat = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_ack  = 1'b0;
    endtask

    task automatic req_m0(input logic [15:0] adr, input logic [31:0] dat);
        m0_adr = adr; m0_dat = dat; m0_we = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
    endtask

    task automatic req_m1(input logic [15:0] adr, input logic [31:0] dat);
        m1_adr = adr; m1_dat = dat; m1_we = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        idle_inputs();
        req_m0(16'hFFFF, 32'hDEAD_BEEF);
        s_ack = 1'b1;
        #3;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL reset_ctl: got %b want 0000000", ctl); end
        n_cmp++; if (s_adr !== 16'h0) begin n_bad++; $display("FAIL reset_s_adr: got %h want 0000", s_adr); end
        n_cmp++; if (s_dat !== 32'h0) begin n_bad++; $display("FAIL reset_s_dat: got %h want 00000000", s_dat); end
        tick();
        tick();
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL reset_held_ctl: got %b want 0000000", ctl); end
        idle_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_m0;
        req_m0(16'h0004, 32'h0000_0010);
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL single_req_cycle: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (ctl !== 7'b111_0000) begin n_bad++; $display("FAIL single_grant_ctl: got %b want 1110000", ctl); end
        n_cmp++; if (s_adr !== 16'h0004) begin n_bad++; $display("FAIL single_s_adr: got %h want 0004", s_adr); end
        n_cmp++; if (s_dat !== 32'h0000_0010) begin n_bad++; $display("FAIL single_s_dat: got %h want 00000010", s_dat); end
        tick();
        s_ack = 1'b1;
        #1;
        n_cmp++; if (ctl !== 7'b111_1000) begin n_bad++; $display("FAIL single_ack: got %b want 1111000", ctl); end
        tick();
        idle_inputs();
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL single_release: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL single_idle: got %b want 0000000", ctl); end
    endtask

    task automatic test_both_same_cycle;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        req_m0(16'h0100, 32'hAAAA_0000);
        req_m1(16'h0200, 32'h0000_5555);
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL both_req_cycle: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (s_adr !== 16'h0100) begin n_bad++; $display("FAIL both_first_m0_adr: got %h want 0100", s_adr); end
        n_cmp++; if (s_dat !== 32'hAAAA_0000) begin n_bad++; $display("FAIL both_first_m0_dat: got %h want aaaa0000", s_dat); end
        s_ack = 1'b1;
        #1;
        n_cmp++; if (ctl !== 7'b111_1000) begin n_bad++; $display("FAIL both_m0_ack: got %b want 1111000", ctl); end
        tick();
        m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; s_ack = 1'b0;
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL both_m0_drop: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (ctl !== 7'b111_0000) begin n_bad++; $display("FAIL both_handover_ctl: got %b want 1110000", ctl); end
        n_cmp++; if (s_adr !== 16'h0200) begin n_bad++; $display("FAIL both_handover_adr: got %h want 0200", s_adr); end
        s_ack = 1'b1;
        #1;
        n_cmp++; if (ctl !== 7'b111_0100) begin n_bad++; $display("FAIL both_m1_ack: got %b want 1110100", ctl); end
        tick();
        idle_inputs();
        tick();
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL both_idle: got %b want 0000000", ctl); end
    endtask

    task automatic test_bus_lock;
        req_m1(16'h0300, 32'h1111_1111);
        tick();
        req_m0(16'h0400, 32'h2222_2222);
        for (int i = 0; i < 3; i++) begin
            m1_adr = 16'h0300 + 16'(i);
            s_ack  = 1'b1;
            #1;
            n_cmp++; if (s_adr !== 16'h0300 + 16'(i)) begin n_bad++; $display("FAIL lock_beat%0d_adr: got %h want %h", i, s_adr, 16'h0300 + 16'(i)); end
            n_cmp++; if (ctl !== 7'b111_0100) begin n_bad++; $display("FAIL lock_beat%0d_ack: got %b want 1110100", i, ctl); end
            tick();
        end
        m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; s_ack = 1'b0;
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL lock_m1_drop: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (s_adr !== 16'h0400) begin n_bad++; $display("FAIL lock_m0_grant_adr: got %h want 0400", s_adr); end
        s_ack = 1'b1;
        #1;
        n_cmp++; if (ctl !== 7'b111_1000) begin n_bad++; $display("FAIL lock_m0_ack: got %b want 1111000", ctl); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_stray_ack;
        s_ack = 1'b1;
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL stray_idle_ack: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL stray_idle_ack2: got %b want 0000000", ctl); end
        s_ack = 1'b0;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 16'h0010;
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL stray_still_idle: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (ctl !== 7'b110_0000) begin n_bad++; $display("FAIL stray_grant: got %b want 1100000", ctl); end
        m0_stb = 1'b0;
        s_ack  = 1'b1;
        #1;
        n_cmp++; if (ctl !== 7'b100_0000) begin n_bad++; $display("FAIL stray_ack_no_stb: got %b want 1000000", ctl); end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        req_m1(16'h0500, 32'h3333_3333);
        tick();
        n_cmp++; if (ctl !== 7'b111_0000) begin n_bad++; $display("FAIL rmid_grant1: got %b want 1110000", ctl); end
        #1;
        s_ack = 1'b1;
        rst   = 1'b0;
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL rmid_drop: got %b want 0000000", ctl); end
        n_cmp++; if (s_adr !== 16'h0000) begin n_bad++; $display("FAIL rmid_s_adr: got %h want 0000", s_adr); end
        tick();
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL rmid_held: got %b want 0000000", ctl); end
        s_ack = 1'b0;
        req_m0(16'h0600, 32'h4444_4444);
        rst = 1'b1;
        #1;
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL rmid_release_idle: got %b want 0000000", ctl); end
        tick();
        n_cmp++; if (s_adr !== 16'h0600) begin n_bad++; $display("FAIL rmid_ptr_m0_wins: got %h want 0600", s_adr); end
        n_cmp++; if (ctl !== 7'b111_0000) begin n_bad++; $display("FAIL rmid_regrant: got %b want 1110000", ctl); end
        idle_inputs();
        tick();
        tick();
    endtask

    task automatic test_timeout;
        req_m0(16'h0700, 32'h5555_5555);
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            n_cmp++; if (ctl !== 7'b111_0000) begin n_bad++; $display("FAIL tmo_stall%0d: got %b want 1110000", k, ctl); end
            tick();
        end
        n_cmp++; if (ctl !== 7'b000_0010) begin n_bad++; $display("FAIL tmo_abort: got %b want 0000010", ctl); end
        idle_inputs();
        tick();
        n_cmp++; if (ctl !== 7'b000_0000) begin n_bad++; $display("FAIL tmo_idle: got %b want 0000000", ctl); end
        req_m0(16'h0800, 32'h6666_6666);
        req_m1(16'h0900, 32'h7777_7777);
        tick();
        n_cmp++; if (s_adr !== 16'h0900) begin n_bad++; $display("FAIL tmo_ptr_m1_wins: got %h want 0900", s_adr); end
        n_cmp++; if (ctl !== 7'b111_0000) begin n_bad++; $display("FAIL tmo_regrant: got %b want 1110000", ctl); end
`else
        for (int k = 0; k < 12; k++) begin
            n_cmp++; if (ctl !== 7'b111_0000) begin n_bad++; $display("FAIL noabort_stall%0d: got %b want 1110000", k, ctl); end
            tick();
        end
`endif
        idle_inputs();
        tick();
        tick();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_m0();
        test_both_same_cycle();
        test_bus_lock();
        test_stray_ack();
        test_reset_mid();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
